position_tracker: RTL and testbench
===================================

POSITION_TRACKER -- requirements
Module: position_tracker

Interface
REQ-001 SHALL have parameters: X_MAX, default 159, largest legal X; Y_MAX, default 119, largest legal Y; X_INIT, default 80, X after reset; Y_INIT, default 60, Y after reset.
REQ-002 clock  in  1  single system clock, all state on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 moveRight, moveLeft, moveUp, moveDown  in  1 each  one-cycle step pulses from the speed/position generators.
REQ-005 posX  out  8 and posY  out  7  current committed position.
REQ-006 drawReq  out  1, drawX  out  8, drawY  out  7, drawErase  out  1 (1 = background colour)  request to pixel plotter.
REQ-007 drawAck  in  1  plotter has consumed the current request.
REQ-008 hitWall  out  1  one-cycle pulse when a step is blocked at a boundary.

Function
REQ-009 SHALL keep per axis a pending register {pendPos, pendNeg}; a move pulse sets its bit in the cycle after it is sampled.
REQ-010 Opposite pulses in the same cycle, or a pulse opposing an already-pending bit, SHALL clear both bits of that axis (cancel).
REQ-011 Repeated same-direction pulses before commit SHALL merge: at most one step per axis per update round.
REQ-012 FSM states SHALL be INIT_DRAW, IDLE, ERASE, UPDATE, DRAW.
REQ-013 INIT_DRAW: drawReq=1, drawErase=0, draw coords = posX/posY; on drawAck -> IDLE.
REQ-014 IDLE: any pending bit set -> ERASE, else stay.
REQ-015 ERASE: drawReq=1, drawErase=1, draw coords = old posX/posY; on drawAck -> UPDATE.
REQ-016 UPDATE (exactly one cycle): apply pending step per axis, clear pending, -> DRAW; right = X+1, left = X-1, down = Y+1, up = Y-1.
REQ-017 Pulses sampled during the UPDATE cycle SHALL survive into the next round.
REQ-018 DRAW: drawReq=1, drawErase=0, draw coords = new posX/posY; on drawAck -> IDLE.
REQ-019 drawReq, drawX, drawY and drawErase SHALL be stable while drawReq=1 and drawAck=0; drawReq SHALL be low in the cycle after drawAck is sampled.
REQ-020 drawAck while drawReq=0 SHALL be ignored.
REQ-021 Latency: pulse in cycle N gives pending in N+1 and ERASE with drawReq=1 in N+2 when the FSM was IDLE.
REQ-022 posX/posY SHALL change only on the UPDATE edge.

Reset
REQ-023 resetn low SHALL immediately force: posX=X_INIT, posY=Y_INIT, pending cleared, drawReq=0, drawErase=0, hitWall=0, state INIT_DRAW.
REQ-024 Reset mid-handshake SHALL abandon the transaction; after release the first request is INIT_DRAW at X_INIT/Y_INIT.

Configuration
REQ-025 Macro POSITION_WRAP_EN: when defined, a step beyond a bound wraps (X_MAX+1 -> 0, 0-1 -> X_MAX; same for Y) and hitWall is tied 0.
REQ-026 Without POSITION_WRAP_EN, a step beyond a bound is clamped (position unchanged) and hitWall pulses high for the cycle after UPDATE; one pulse per round even if both axes are blocked.

Structure
REQ-027 Package position_pkg SHALL hold X_W=8, Y_W=7, default bounds and init values, and the FSM state enum.
REQ-028 Sub-module position_axis (pending register, cancel/merge logic, clamp/wrap step) SHALL be instantiated once for X and once for Y.

Verification
REQ-029 Reset release, drawAck held 1 -> INIT_DRAW request at (80,60), drawErase=0, then IDLE.
REQ-030 moveRight pulse, ack 1 cycle after each req -> erase (80,60), draw (81,60), posX=81.
REQ-031 moveLeft and moveRight in same cycle -> no drawReq; position stays (80,60).
REQ-032 Position (159,0), moveRight+moveUp -> erase/draw at (159,0), hitWall 1 cycle; with POSITION_WRAP_EN -> draw (0,119), hitWall 0.
REQ-033 Three moveDown pulses during a 10-cycle-stalled ERASE -> single step, Y 60 -> 61; drawX/drawY stable across stall.
REQ-034 resetn low while DRAW pending ack at (81,60) -> drawReq falls at once; after release, INIT_DRAW at (80,60).

Source files
------------

// File: rtl/position_pkg.sv
// rtl/position_pkg.sv - shared widths, default bounds and FSM states for position_tracker
package position_pkg;
   localparam int X_W        = 8;
   localparam int Y_W        = 7;
   localparam int X_MAX_DEF  = 159;
   localparam int Y_MAX_DEF  = 119;
   localparam int X_INIT_DEF = 80;
   localparam int Y_INIT_DEF = 60;

   typedef enum logic [2:0] {
      INIT_DRAW,
      IDLE,
      ERASE,
      UPDATE,
      DRAW
   } state_t;
endpackage

// File: rtl/position_axis.sv
// rtl/position_axis.sv - one axis: pending step register with cancel/merge, clamped or wrapped step
// POSITION_WRAP_EN selects wrap-around at the bounds instead of clamping.
module position_axis #(
   parameter int W    = 8,
   parameter int MAX  = 159,
   parameter int INIT = 80
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         step_pos,
   input  logic         step_neg,
   input  logic         apply,
   output logic [W-1:0] pos,
   output logic         pending,
   output logic         blocked
);
   localparam logic [W-1:0] MAX_V  = W'(MAX);
   localparam logic [W-1:0] INIT_V = W'(INIT);

   logic         pend_pos, pend_neg;
   logic         base_pos, base_neg;
   logic         nxt_pos, nxt_neg;
   logic [W-1:0] pos_nxt;

   // The commit clears the old round, but a pulse arriving in that same cycle starts the next one.
   always_comb begin
      base_pos = apply ? 1'b0 : pend_pos;
      base_neg = apply ? 1'b0 : pend_neg;
      nxt_pos  = base_pos;
      nxt_neg  = base_neg;
      if (step_pos && step_neg) begin
         nxt_pos = 1'b0;
         nxt_neg = 1'b0;
      end else if (step_pos) begin
         nxt_pos = !base_neg;
         nxt_neg = 1'b0;
      end else if (step_neg) begin
         nxt_neg = !base_pos;
         nxt_pos = 1'b0;
      end
   end

   always_comb begin
      pos_nxt = pos;
      blocked = 1'b0;
      if (apply && pend_pos) begin
         if (pos == MAX_V) begin
`ifdef POSITION_WRAP_EN
            pos_nxt = '0;
`else
            blocked = 1'b1;
`endif
         end else begin
            pos_nxt = pos + W'(1);
         end
      end else if (apply && pend_neg) begin
         if (pos == '0) begin
`ifdef POSITION_WRAP_EN
            pos_nxt = MAX_V;
`else
            blocked = 1'b1;
`endif
         end else begin
            pos_nxt = pos - W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pend_pos <= 1'b0;
         pend_neg <= 1'b0;
         pos      <= INIT_V;
      end else begin
         pend_pos <= nxt_pos;
         pend_neg <= nxt_neg;
         pos      <= pos_nxt;
      end
   end

   assign pending = pend_pos | pend_neg;
endmodule

// File: rtl/position_tracker.sv
// rtl/position_tracker.sv - tracks an on-screen position and sequences erase/draw requests to a plotter
// POSITION_WRAP_EN: wrap at the bounds (hitWall stays 0) instead of clamping.
module position_tracker
   import position_pkg::*;
#(
   parameter int X_MAX  = X_MAX_DEF,
   parameter int Y_MAX  = Y_MAX_DEF,
   parameter int X_INIT = X_INIT_DEF,
   parameter int Y_INIT = Y_INIT_DEF
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           moveRight,
   input  logic           moveLeft,
   input  logic           moveUp,
   input  logic           moveDown,
   output logic [X_W-1:0] posX,
   output logic [Y_W-1:0] posY,
   output logic           drawReq,
   output logic [X_W-1:0] drawX,
   output logic [Y_W-1:0] drawY,
   output logic           drawErase,
   input  logic           drawAck,
   output logic           hitWall
);
   state_t state, state_nxt;
   logic   armed;
   logic   apply;
   logic   x_pend, y_pend, x_blk, y_blk;

   position_axis #(.W(X_W), .MAX(X_MAX), .INIT(X_INIT)) u_axis_x (
      .clock    (clock),
      .resetn   (resetn),
      .step_pos (moveRight),
      .step_neg (moveLeft),
      .apply    (apply),
      .pos      (posX),
      .pending  (x_pend),
      .blocked  (x_blk)
   );

   position_axis #(.W(Y_W), .MAX(Y_MAX), .INIT(Y_INIT)) u_axis_y (
      .clock    (clock),
      .resetn   (resetn),
      .step_pos (moveDown),
      .step_neg (moveUp),
      .apply    (apply),
      .pos      (posY),
      .pending  (y_pend),
      .blocked  (y_blk)
   );

   // armed holds the first request off until the cycle after reset release.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= INIT_DRAW;
         armed   <= 1'b0;
         hitWall <= 1'b0;
      end else begin
         state   <= state_nxt;
         armed   <= 1'b1;
         hitWall <= apply & (x_blk | y_blk);
      end
   end

   always_comb begin
      state_nxt = state;
      drawReq   = 1'b0;
      drawErase = 1'b0;
      apply     = 1'b0;
      case (state)
         INIT_DRAW: begin
            drawReq = armed;
            if (armed && drawAck) state_nxt = IDLE;
         end
         IDLE: begin
            if (x_pend || y_pend) state_nxt = ERASE;
         end
         ERASE: begin
            drawReq   = 1'b1;
            drawErase = 1'b1;
            if (drawAck) state_nxt = UPDATE;
         end
         UPDATE: begin
            apply     = 1'b1;
            state_nxt = DRAW;
         end
         DRAW: begin
            drawReq = 1'b1;
            if (drawAck) state_nxt = IDLE;
         end
         default: state_nxt = INIT_DRAW;
      endcase
   end

   // Position only moves on the UPDATE edge, so the draw coordinates hold through any stall.
   assign drawX = posX;
   assign drawY = posY;
endmodule

// File: tb/tb_position_tracker.sv
// tb/tb_position_tracker.sv - directed self-checking bench for position_tracker
module tb_position_tracker;
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       moveRight = 1'b0, moveLeft = 1'b0, moveUp = 1'b0, moveDown = 1'b0;
   logic       drawAck = 1'b0;
   logic [7:0] posX, drawX;
   logic [6:0] posY, drawY;
   logic       drawReq, drawErase, hitWall;
   int         tests = 0;
   int         fails = 0;

   position_tracker dut (
      .clock     (clock),
      .resetn    (resetn),
      .moveRight (moveRight),
      .moveLeft  (moveLeft),
      .moveUp    (moveUp),
      .moveDown  (moveDown),
      .posX      (posX),
      .posY      (posY),
      .drawReq   (drawReq),
      .drawX     (drawX),
      .drawY     (drawY),
      .drawErase (drawErase),
      .drawAck   (drawAck),
      .hitWall   (hitWall)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_req(input string tag, input logic erase, input logic [7:0] x, input logic [6:0] y);
      int n = 0;
      while (!drawReq && n < 20) begin
         tick();
         n++;
      end
      check({tag, ".req"}, 32'(drawReq), 32'd1);
      check({tag, ".erase"}, 32'(drawErase), 32'(erase));
      check({tag, ".x"}, 32'(drawX), 32'(x));
      check({tag, ".y"}, 32'(drawY), 32'(y));
   endtask

   task automatic ack(input string tag);
      drawAck = 1'b1;
      tick();
      drawAck = 1'b0;
      check({tag, ".req_low"}, 32'(drawReq), 32'd0);
   endtask

   task automatic quiet(input string tag, input int n);
      logic seen = 1'b0;
      repeat (n) begin
         tick();
         if (drawReq !== 1'b0) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   task automatic pulse(input logic r, input logic l, input logic u, input logic d);
      moveRight = r; moveLeft = l; moveUp = u; moveDown = d;
      tick();
      moveRight = 1'b0; moveLeft = 1'b0; moveUp = 1'b0; moveDown = 1'b0;
   endtask

   initial begin
      logic stable;
      drawAck = 1'b1;
      #12;
      check("rst.posX", 32'(posX), 32'd80);
      check("rst.posY", 32'(posY), 32'd60);
      check("rst.req", 32'(drawReq), 32'd0);
      check("rst.erase", 32'(drawErase), 32'd0);
      check("rst.hit", 32'(hitWall), 32'd0);

      resetn = 1'b1;
      expect_req("init", 1'b0, 8'd80, 7'd60);
      tick();
      check("init.idle", 32'(drawReq), 32'd0);
      drawAck = 1'b0;
      quiet("init.quiet", 3);

      pulse(1, 0, 0, 0);
      check("lat.n1", 32'(drawReq), 32'd0);
      tick();
      check("lat.n2", 32'(drawReq), 32'd1);
      expect_req("right.erase", 1'b1, 8'd80, 7'd60);
      ack("right.erase");
      check("right.upd_pos", 32'(posX), 32'd80);
      tick();
      expect_req("right.draw", 1'b0, 8'd81, 7'd60);
      check("right.posX", 32'(posX), 32'd81);
      check("right.hit", 32'(hitWall), 32'd0);
      ack("right.draw");

      pulse(0, 1, 0, 0);
      expect_req("left.erase", 1'b1, 8'd81, 7'd60);
      ack("left.erase");
      tick();
      expect_req("left.draw", 1'b0, 8'd80, 7'd60);
      ack("left.draw");

      pulse(1, 1, 0, 0);
      quiet("opp.quiet", 6);
      check("opp.posX", 32'(posX), 32'd80);
      check("opp.posY", 32'(posY), 32'd60);

      pulse(0, 0, 0, 1);
      expect_req("merge.erase", 1'b1, 8'd80, 7'd60);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 5) moveDown = 1'b1;
         tick();
         moveDown = 1'b0;
         if (drawReq !== 1'b1 || drawErase !== 1'b1 || drawX !== 8'd80 || drawY !== 7'd60) stable = 1'b0;
      end
      check("merge.stable", 32'(stable), 32'd1);
      ack("merge.erase");
      tick();
      expect_req("merge.draw", 1'b0, 8'd80, 7'd61);
      check("merge.posY", 32'(posY), 32'd61);

      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      check("cancel.drawY", 32'(drawY), 32'd61);
      ack("merge.draw");
      quiet("cancel.quiet", 6);
      check("cancel.posY", 32'(posY), 32'd61);

      pulse(0, 0, 1, 0);
      expect_req("survive.erase", 1'b1, 8'd80, 7'd61);
      ack("survive.erase");
      pulse(1, 0, 0, 0);
      expect_req("survive.draw", 1'b0, 8'd80, 7'd60);
      ack("survive.draw");
      expect_req("survive.erase2", 1'b1, 8'd80, 7'd60);
      ack("survive.erase2");
      tick();
      expect_req("survive.draw2", 1'b0, 8'd81, 7'd60);

      resetn = 1'b0;
      #1;
      check("midrst.req", 32'(drawReq), 32'd0);
      check("midrst.posX", 32'(posX), 32'd80);
      check("midrst.posY", 32'(posY), 32'd60);
      tick();
      resetn = 1'b1;
      expect_req("midrst.init", 1'b0, 8'd80, 7'd60);
      ack("midrst.init");

      drawAck = 1'b1;
      for (int i = 0; i < 60; i++) begin
         pulse(1, 0, 1, 0);
         repeat (5) tick();
      end
      for (int i = 0; i < 19; i++) begin
         pulse(1, 0, 0, 0);
         repeat (5) tick();
      end
      drawAck = 1'b0;
      check("corner.posX", 32'(posX), 32'd159);
      check("corner.posY", 32'(posY), 32'd0);

      pulse(1, 0, 1, 0);
      expect_req("wall.erase", 1'b1, 8'd159, 7'd0);
      check("wall.hit_pre", 32'(hitWall), 32'd0);
      ack("wall.erase");
      tick();
`ifdef POSITION_WRAP_EN
      expect_req("wall.draw", 1'b0, 8'd0, 7'd119);
      check("wall.hit", 32'(hitWall), 32'd0);
`else
      expect_req("wall.draw", 1'b0, 8'd159, 7'd0);
      check("wall.hit", 32'(hitWall), 32'd1);
`endif
      ack("wall.draw");
      check("wall.hit_post", 32'(hitWall), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
